// File: rtl/inv_shift_rows_serial.sv
// inv_shift_rows_serial: byte-serial AES InvShiftRows buffer with NUM_BANKS (1 or 2) 16-byte banks.
// Latency: first output byte valid the cycle after input byte 15; 1 byte/cycle sustained with 2 banks.
// Backpressure: out_ready low holds out_valid/out_data; in_ready low while the write bank is FULL.
// Optional: define ISR_MODE_SEL_EN to add a per-block mode input (0 = inverse, 1 = forward ShiftRows).
module inv_shift_rows_serial #(
  parameter int NUM_BANKS = 2
) (
  input  logic       clk,
  input  logic       rst,
`ifdef ISR_MODE_SEL_EN
  input  logic       mode,
`endif
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_st_t;

  bank_st_t   bank_st     [NUM_BANKS];
  bank_st_t   bank_st_nxt [NUM_BANKS];
  logic [7:0] mem         [NUM_BANKS][16];

  logic [3:0] wr_idx;
  logic [3:0] rd_idx;
  logic       wr_bank;
  logic       rd_bank;
  logic       wr_fire;
  logic       rd_fire;
  logic       rd_fwd;
  logic [1:0] rd_row;
  logic [1:0] rd_col;
  logic [1:0] src_col;
  logic [3:0] src_idx;

  // Handshakes depend only on registered bank state, never on the opposite valid/ready.
  always_comb begin
    in_ready  = (bank_st[wr_bank] != FULL);
    out_valid = (bank_st[rd_bank] == FULL);
    wr_fire   = in_valid & in_ready;
    rd_fire   = out_valid & out_ready;
  end

  // Per-bank next state; a write-complete and a read-complete on different banks both apply.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_st_nxt[b] = bank_st[b];
      if (wr_fire && (wr_bank == 1'(b)))
        bank_st_nxt[b] = (wr_idx == 4'd15) ? FULL : FILLING;
      if (rd_fire && (rd_bank == 1'(b)) && (rd_idx == 4'd15))
        bank_st_nxt[b] = EMPTY;
    end
  end

  // Bank state registers.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rst) bank_st[b] <= EMPTY;
      else     bank_st[b] <= bank_st_nxt[b];
    end
  end

  // Write/read byte pointers; each wraps after byte 15 and moves to the other bank when there is one.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx  <= 4'd0;
      rd_idx  <= 4'd0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
    end else begin
      if (wr_fire) begin
        wr_idx <= wr_idx + 4'd1;
        if ((wr_idx == 4'd15) && (NUM_BANKS == 2)) wr_bank <= ~wr_bank;
      end
      if (rd_fire) begin
        rd_idx <= rd_idx + 4'd1;
        if ((rd_idx == 4'd15) && (NUM_BANKS == 2)) rd_bank <= ~rd_bank;
      end
    end
  end

  // Byte storage in input order; contents are qualified by bank state so no reset is needed.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_bank][wr_idx] <= in_data;
  end

`ifdef ISR_MODE_SEL_EN
  logic bank_mode [NUM_BANKS];

  // Mode is captured with byte 0 so the whole block drains with one mapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANKS; b++) bank_mode[b] <= 1'b0;
    end else if (wr_fire && (wr_idx == 4'd0)) begin
      bank_mode[wr_bank] <= mode;
    end
  end

  assign rd_fwd = bank_mode[rd_bank];
`else
  assign rd_fwd = 1'b0;
`endif

  // Output byte r+4c reads source column (c-r) mod 4 (inverse) or (c+r) mod 4 (forward).
  always_comb begin
    rd_row   = rd_idx[1:0];
    rd_col   = rd_idx[3:2];
    src_col  = rd_fwd ? (rd_col + rd_row) : (rd_col - rd_row);
    src_idx  = {src_col, rd_row};
    out_data = out_valid ? mem[rd_bank][src_idx] : 8'h00;
    out_last = out_valid & (rd_idx == 4'd15);
  end

endmodule

// File: tb/tb_inv_shift_rows_serial.sv
// tb_inv_shift_rows_serial: randomized and directed checks of inv_shift_rows_serial against a byte-array model.
// Two instances (2 banks and 1 bank) share stimulus; sel routes in_valid and selects observed outputs.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_inv_shift_rows_serial;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b0;
  logic       mode = 1'b0;
  logic       sel = 1'b0;

  logic       iv2, ir2, ov2, ol2;
  logic       iv1, ir1, ov1, ol1;
  logic [7:0] od2, od1;

  logic       in_ready_s, out_valid_s, out_last_s;
  logic [7:0] out_data_s;

  always #5 clk = ~clk;

  assign iv2 = in_valid & ~sel;
  assign iv1 = in_valid & sel;
  assign in_ready_s  = sel ? ir1 : ir2;
  assign out_valid_s = sel ? ov1 : ov2;
  assign out_data_s  = sel ? od1 : od2;
  assign out_last_s  = sel ? ol1 : ol2;

  inv_shift_rows_serial #(.NUM_BANKS(2)) u_dut2 (
    .clk(clk), .rst(rst),
`ifdef ISR_MODE_SEL_EN
    .mode(mode),
`endif
    .in_valid(iv2), .in_ready(ir2), .in_data(in_data),
    .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .out_last(ol2)
  );

  inv_shift_rows_serial #(.NUM_BANKS(1)) u_dut1 (
    .clk(clk), .rst(rst),
`ifdef ISR_MODE_SEL_EN
    .mode(mode),
`endif
    .in_valid(iv1), .in_ready(ir1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_last(ol1)
  );

  localparam logic [127:0] V1 = 128'h63C0AB20EB2F30CB9F93AF2BA092C7A2;
  localparam logic [127:0] E1 = 128'h6392AFCBEBC0C72B9F2FABA2A0933020;
  localparam logic [127:0] V2 = 128'h6AA0303D594E9CF4CB48989BBD129E8B;

  int         n_chk = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         out_valid_first = -1;
  logic [7:0] in_q[$];
  bit         mode_q[$];
  logic [7:0] got_q[$];
  bit         last_q[$];
  int         in_fire_cyc[$];
  int         out_fire_cyc[$];
  bit         pv_hold = 1'b0;
  logic [7:0] pv_data = 8'h00;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: out byte r+4c takes input byte r+4*((c-r) mod 4), or (c+r) mod 4 when forward.
  function automatic logic [127:0] ref_map(input logic [127:0] s, input bit fwd);
    logic [7:0]   b [16];
    logic [127:0] r;
    int           sc;
    for (int k = 0; k < 16; k++) b[k] = s[127-8*k -: 8];
    r = '0;
    for (int row = 0; row < 4; row++) begin
      for (int col = 0; col < 4; col++) begin
        sc = fwd ? ((col + row) % 4) : ((col - row + 4) % 4);
        r[127-8*(row+4*col) -: 8] = b[row + 4*sc];
      end
    end
    return r;
  endfunction

  task automatic push_block(input logic [127:0] s, input bit m);
    for (int k = 0; k < 16; k++) begin
      in_q.push_back(s[127-8*k -: 8]);
      mode_q.push_back((k == 0) ? m : 1'($urandom));
    end
  endtask

  task automatic pop_block(output logic [127:0] s, output logic [15:0] lastv);
    s = '0;
    lastv = '0;
    for (int k = 0; k < 16; k++) begin
      if (got_q.size() > 0) begin
        s[127-8*k -: 8] = got_q.pop_front();
        lastv[k] = last_q.pop_front();
      end
    end
  endtask

  task automatic clear_logs();
    got_q.delete();
    last_q.delete();
    in_fire_cyc.delete();
    out_fire_cyc.delete();
    out_valid_first = -1;
  endtask

  // One clock: check hold behaviour, drive inputs for the next rising edge, log transfers.
  task automatic cycle(input int iv_pct, input int or_pct);
    @(negedge clk);
    cyc++;
    if (pv_hold) begin
      chk("hold_valid", out_valid_s, 1);
      chk("hold_data", out_data_s, pv_data);
    end
    in_valid  = (in_q.size() > 0) && (int'($urandom_range(99)) < iv_pct);
    in_data   = in_valid ? in_q[0] : 8'($urandom);
    mode      = in_valid ? mode_q[0] : 1'b0;
    out_ready = (int'($urandom_range(99)) < or_pct);
    if (in_valid && in_ready_s) begin
      void'(in_q.pop_front());
      void'(mode_q.pop_front());
      in_fire_cyc.push_back(cyc);
    end
    if (out_valid_s && out_ready) begin
      got_q.push_back(out_data_s);
      last_q.push_back(out_last_s);
      out_fire_cyc.push_back(cyc);
    end
    if (out_valid_s && (out_valid_first < 0)) out_valid_first = cyc;
    pv_hold = out_valid_s && !out_ready;
    pv_data = out_data_s;
  endtask

  task automatic run(input string tag, input int target, input int budget, input int iv_pct, input int or_pct);
    int left;
    left = budget;
    while ((got_q.size() < target) && (left > 0)) begin
      cycle(iv_pct, or_pct);
      left--;
    end
    chk(tag, got_q.size(), target);
  endtask

  task automatic do_reset(input bit s);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    sel = s;
    @(negedge clk);
    rst = 1'b0;
    in_q.delete();
    mode_q.delete();
    pv_hold = 1'b0;
    clear_logs();
  endtask

  initial begin
    logic [127:0] blk, v3;
    logic [15:0]  lastv;
    logic [127:0] exp_q[$];

    // Reset state of both instances.
    do_reset(1'b0);
    chk("rst_in_ready2", ir2, 1);
    chk("rst_out_valid2", ov2, 0);
    chk("rst_out_data2", od2, 0);
    chk("rst_out_last2", ol2, 0);
    chk("rst_in_ready1", ir1, 1);
    chk("rst_out_valid1", ov1, 0);

    // Single block with the known vector.
    push_block(V1, 1'b0);
    run("t1_timeout", 16, 200, 100, 100);
    pop_block(blk, lastv);
    chk("t1_data", blk, E1);
    chk("t1_model", blk, ref_map(V1, 1'b0));
    chk("t1_last", lastv, 16'h8000);
    chk("t1_latency", out_valid_first - in_fire_cyc[15], 1);

    // Back-to-back blocks: no output bubble.
    clear_logs();
    push_block(V1, 1'b0);
    push_block(V2, 1'b0);
    run("t2_timeout", 32, 200, 100, 100);
    chk("t2_span", out_fire_cyc[31] - out_fire_cyc[0], 31);
    pop_block(blk, lastv);
    chk("t2_blk0", blk, E1);
    pop_block(blk, lastv);
    chk("t2_blk1_head", blk[127:96], 32'h6A1298F4);
    chk("t2_blk1", blk, ref_map(V2, 1'b0));
    chk("t2_last", lastv, 16'h8000);

    // Backpressure: both banks fill, then input stalls.
    clear_logs();
    v3 = {$urandom, $urandom, $urandom, $urandom};
    push_block(V1, 1'b0);
    push_block(V2, 1'b0);
    push_block(v3, 1'b0);
    for (int i = 0; i < 40; i++) cycle(100, 0);
    chk("t3_accepted", in_fire_cyc.size(), 32);
    chk("t3_in_ready", in_ready_s, 0);
    chk("t3_out_valid", out_valid_s, 1);
    chk("t3_out_data", out_data_s, 8'h63);
    run("t3_timeout_a", 16, 100, 100, 100);
    chk("t3_rdy_at_last", in_ready_s, 0);
    @(posedge clk);
    #1;
    chk("t3_rdy_after", in_ready_s, 1);
    run("t3_timeout_b", 48, 300, 100, 100);
    pop_block(blk, lastv);
    chk("t3_blk0", blk, E1);
    pop_block(blk, lastv);
    chk("t3_blk1", blk, ref_map(V2, 1'b0));
    pop_block(blk, lastv);
    chk("t3_blk2", blk, ref_map(v3, 1'b0));

    // Reset in the middle of a block.
    clear_logs();
    push_block(v3, 1'b0);
    for (int i = 0; (i < 50) && (in_fire_cyc.size() < 7); i++) cycle(100, 100);
    chk("t4_partial", in_fire_cyc.size(), 7);
    do_reset(1'b0);
    chk("t4_in_ready", in_ready_s, 1);
    chk("t4_out_valid", out_valid_s, 0);
    chk("t4_out_data", out_data_s, 0);
    push_block(V1, 1'b0);
    run("t4_timeout", 16, 200, 100, 100);
    pop_block(blk, lastv);
    chk("t4_data", blk, E1);

    // Random traffic and random data.
    clear_logs();
    exp_q.delete();
    for (int n = 0; n < 20; n++) begin
      bit m;
      blk = {$urandom, $urandom, $urandom, $urandom};
`ifdef ISR_MODE_SEL_EN
      m = 1'($urandom);
`else
      m = 1'b0;
`endif
      push_block(blk, m);
      exp_q.push_back(ref_map(blk, m));
    end
    run("t5_timeout", 320, 6000, 70, 60);
    for (int n = 0; n < 20; n++) begin
      pop_block(blk, lastv);
      chk($sformatf("t5_blk%0d", n), blk, exp_q[n]);
      chk($sformatf("t5_last%0d", n), lastv, 16'h8000);
    end

    // Single-bank instance: no overlap between blocks.
    do_reset(1'b1);
    chk("t6_rst_ready", in_ready_s, 1);
    push_block(V1, 1'b0);
    push_block(V2, 1'b0);
    run("t6_timeout", 32, 300, 100, 100);
    chk("t6_gap", in_fire_cyc[16] - in_fire_cyc[15], 17);
    chk("t6_ready_back", in_fire_cyc[16] - out_fire_cyc[15], 1);
    pop_block(blk, lastv);
    chk("t6_blk0", blk, E1);
    pop_block(blk, lastv);
    chk("t6_blk1", blk, ref_map(V2, 1'b0));

`ifdef ISR_MODE_SEL_EN
    // Forward mapping selected per block.
    do_reset(1'b0);
    push_block(E1, 1'b1);
    push_block(V1, 1'b0);
    run("t7_timeout", 32, 300, 100, 100);
    pop_block(blk, lastv);
    chk("t7_fwd", blk, V1);
    pop_block(blk, lastv);
    chk("t7_inv", blk, E1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required below 1000000", $time);
    $fatal(1, "watchdog");
  end

endmodule
